// File: rtl/rgb_pwm_pkg.sv
// rtl/rgb_pwm_pkg.sv - shared register map, field positions and duty-word helpers for rgb_pwm_array
package rgb_pwm_pkg;

    localparam int unsigned MAX_DUTY_W = 10;

    localparam int unsigned GCTRL    = 0;
    localparam int unsigned STATUS   = 1;
    localparam int unsigned TGT_BASE = 2;
    localparam int unsigned CUR_BASE = 3;

    localparam int unsigned EN_BIT   = 31;
    localparam int unsigned FADE_BIT = 30;

    typedef logic [MAX_DUTY_W-1:0] duty_t;

    typedef struct packed {
        duty_t r;
        duty_t g;
        duty_t b;
    } rgb_duty_t;

    // Fields are stored at full MAX_DUTY_W width; bits above dw stay zero.
    function automatic rgb_duty_t duty_from_word(input logic [31:0] w, input int unsigned dw);
        logic [31:0] m;
        rgb_duty_t   d;
        m   = (32'd1 << dw) - 32'd1;
        d.b = duty_t'(w & m);
        d.g = duty_t'((w >> dw) & m);
        d.r = duty_t'((w >> (2 * dw)) & m);
        return d;
    endfunction

    function automatic logic [31:0] duty_to_word(input rgb_duty_t d, input int unsigned dw);
        return (32'(d.r) << (2 * dw)) | (32'(d.g) << dw) | 32'(d.b);
    endfunction

    function automatic duty_t duty_step(input duty_t cur, input duty_t tgt);
        if (cur < tgt) begin
            return cur + duty_t'(1);
        end else if (cur > tgt) begin
            return cur - duty_t'(1);
        end
        return cur;
    endfunction

endpackage

// File: rtl/rgb_pwm_array_if.sv
// rtl/rgb_pwm_array_if.sv - Wishbone classic register bus bundle for rgb_pwm_array
interface rgb_pwm_array_if #(
    parameter int ADR_W = 6
);
    logic [ADR_W-1:0] adr;
    logic [31:0]      dat_w;
    logic [3:0]       sel;
    logic             we;
    logic             cyc;
    logic             stb;
    logic [31:0]      dat_r;
    logic             ack;

    modport master (
        output adr, dat_w, sel, we, cyc, stb,
        input  dat_r, ack
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb,
        output dat_r, ack
    );
endinterface

// File: rtl/rgb_pwm_chan.sv
// rtl/rgb_pwm_chan.sv - one RGB LED: live duty register, wrap-aligned fade stepping, PWM compare
module rgb_pwm_chan
    import rgb_pwm_pkg::*;
#(
    parameter int DUTY_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DUTY_W-1:0] i_pwm,
    input  logic              i_wrap,
    input  logic              i_en,
    input  logic              i_fade,
    input  rgb_duty_t         i_tgt,
    output rgb_duty_t         o_cur,
    output logic [2:0]        o_rgb,
    output logic              o_busy,
    output logic              o_done_pulse
);

    rgb_duty_t  r_cur;
    rgb_duty_t  w_next;
    duty_t      w_pwm;
    logic [2:0] r_rgb;
    logic       w_differs;

    assign w_pwm     = duty_t'(i_pwm);
    assign w_differs = (r_cur != i_tgt);

    always_comb begin
        w_next = i_tgt;
        if (i_fade) begin
            w_next.r = duty_step(r_cur.r, i_tgt.r);
            w_next.g = duty_step(r_cur.g, i_tgt.g);
            w_next.b = duty_step(r_cur.b, i_tgt.b);
        end
    end

    assign o_busy       = i_fade & w_differs;
    assign o_done_pulse = i_wrap & i_fade & w_differs & (w_next == i_tgt);

    // Live duty only moves on wrap so a period is never cut short or stretched.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cur <= '0;
            r_rgb <= 3'b000;
        end else begin
            if (i_wrap) begin
                r_cur <= w_next;
            end
            if (i_en) begin
                r_rgb <= {w_pwm < r_cur.r, w_pwm < r_cur.g, w_pwm < r_cur.b};
            end else begin
                r_rgb <= 3'b000;
            end
        end
    end

    assign o_cur = r_cur;
    assign o_rgb = r_rgb;

endmodule

// File: rtl/rgb_pwm_array.sv
// rtl/rgb_pwm_array.sv - multi-LED RGB PWM controller: Wishbone registers, prescaler, shared PWM counter
module rgb_pwm_array
    import rgb_pwm_pkg::*;
#(
    parameter int NUM_LEDS = 2,
    parameter int DUTY_W   = 10,
    parameter int ADR_W    = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    rgb_pwm_array_if.slave        wb,
    output logic [3*NUM_LEDS-1:0] o_rgb,
    output logic                  o_irq
);

    logic [31:0]       w_idx;
    logic              w_acc;
    logic              w_wr;
    logic              r_ack;
    logic [31:0]       r_dat;
    logic [31:0]       w_rd;
    rgb_duty_t         w_wr_duty;
    logic [NUM_LEDS-1:0] w_clr;

    logic              r_gen;
    logic [15:0]       r_prescale;
    logic [15:0]       r_pcnt;
    logic [DUTY_W-1:0] r_pwm;
    logic              w_tick;
    logic              w_wrap;

    rgb_duty_t           r_tgt [NUM_LEDS];
    logic [NUM_LEDS-1:0] r_led_en;
    logic [NUM_LEDS-1:0] r_fade;
    logic [NUM_LEDS-1:0] r_done;

    rgb_duty_t           w_cur [NUM_LEDS];
    logic [2:0]          w_rgb [NUM_LEDS];
    logic [NUM_LEDS-1:0] w_busy;
    logic [NUM_LEDS-1:0] w_done_pulse;

    logic w_unused;
    assign w_unused = ^wb.adr[1:0];

    assign w_idx     = 32'(wb.adr[ADR_W-1:2]);
    assign w_acc     = wb.cyc & wb.stb & ~r_ack;
    assign w_wr      = w_acc & wb.we & (wb.sel == 4'hF);
    assign w_wr_duty = duty_from_word(wb.dat_w, DUTY_W);
    assign w_clr     = (w_wr && (w_idx == STATUS)) ? wb.dat_w[NUM_LEDS-1:0] : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_acc;
            r_dat <= (w_acc && !wb.we) ? w_rd : 32'd0;
        end
    end

    assign wb.ack   = r_ack;
    assign wb.dat_r = r_dat;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gen      <= 1'b0;
            r_prescale <= '0;
            r_led_en   <= '0;
            r_fade     <= '0;
            for (int k = 0; k < NUM_LEDS; k++) begin
                r_tgt[k] <= '0;
            end
        end else if (w_wr) begin
            if (w_idx == GCTRL) begin
                r_gen      <= wb.dat_w[EN_BIT];
                r_prescale <= wb.dat_w[15:0];
            end
            for (int k = 0; k < NUM_LEDS; k++) begin
                if (w_idx == 32'(TGT_BASE + 2 * k)) begin
                    r_tgt[k]    <= w_wr_duty;
                    r_led_en[k] <= wb.dat_w[EN_BIT];
                    r_fade[k]   <= wb.dat_w[FADE_BIT];
                end
            end
        end
    end

    // A completion on the same edge as its clear keeps the bit set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_done <= '0;
        end else begin
            r_done <= w_done_pulse | (r_done & ~w_clr);
        end
    end

    assign o_irq = |r_done;

    // >= compare lets a lowered PRESCALE tick immediately instead of waiting for a 16-bit wrap.
    assign w_tick = r_gen & (r_pcnt >= r_prescale);
    assign w_wrap = w_tick & (&r_pwm);

    always_ff @(posedge i_clk) begin
        if (i_rst || !r_gen) begin
            r_pcnt <= '0;
            r_pwm  <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
            r_pwm  <= r_pwm + DUTY_W'(1);
        end else begin
            r_pcnt <= r_pcnt + 16'd1;
        end
    end

    always_comb begin
        w_rd = '0;
        if (w_idx == GCTRL) begin
            w_rd = {r_gen, 15'd0, r_prescale};
        end else if (w_idx == STATUS) begin
            w_rd = {16'd0, 8'(w_busy), 8'(r_done)};
        end
        for (int k = 0; k < NUM_LEDS; k++) begin
            if (w_idx == 32'(TGT_BASE + 2 * k)) begin
                w_rd           = duty_to_word(r_tgt[k], DUTY_W);
                w_rd[EN_BIT]   = r_led_en[k];
                w_rd[FADE_BIT] = r_fade[k];
            end
            if (w_idx == 32'(CUR_BASE + 2 * k)) begin
                w_rd = duty_to_word(w_cur[k], DUTY_W);
            end
        end
    end

    for (genvar k = 0; k < NUM_LEDS; k++) begin : g_chan
        rgb_pwm_chan #(
            .DUTY_W(DUTY_W)
        ) u_chan (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_pwm       (r_pwm),
            .i_wrap      (w_wrap),
            .i_en        (r_gen & r_led_en[k]),
            .i_fade      (r_fade[k]),
            .i_tgt       (r_tgt[k]),
            .o_cur       (w_cur[k]),
            .o_rgb       (w_rgb[k]),
            .o_busy      (w_busy[k]),
            .o_done_pulse(w_done_pulse[k])
        );
        assign o_rgb[3*k +: 3] = w_rgb[k];
    end

endmodule
